// File: rtl/vga_theme_if.sv
// Request/status bundle between the VGA control logic and the theme scheduler.
// The scheduler takes the slave side; the request source takes the master side.
interface vga_theme_if;
  logic       frame_tick;
  logic       btn_req;
  logic       kb_req;
  logic [3:0] kb_sel;
  logic [3:0] theme;
  logic [2:0] fade;
  logic       busy;
  logic [2:0] grant;

  modport master (
    output frame_tick, btn_req, kb_req, kb_sel,
    input  theme, fade, busy, grant
  );

  modport slave (
    input  frame_tick, btn_req, kb_req, kb_sel,
    output theme, fade, busy, grant
  );
endinterface

// File: rtl/vga_theme_sched.sv
// Theme scheduler: fade out, swap theme, fade in; kb > btn > auto requests.
// Define VGA_THEME_AUTO_EN to build the inactivity auto-cycle requester.
module vga_theme_sched #(
  parameter int THEME_NUM   = 3,
  parameter int AUTO_FRAMES = 600
) (
  input logic        clk,
  input logic        rst,
  vga_theme_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE, FADE_OUT, SWAP, FADE_IN
  } state_t;

  typedef enum logic [1:0] {
    P_AUTO, P_BTN, P_KB
  } pri_t;

  localparam logic [4:0] TN    = 5'(THEME_NUM);
  localparam logic [3:0] TLAST = 4'(THEME_NUM - 1);

  state_t     state, state_n;
  logic [3:0] theme, theme_n;
  logic [3:0] tgt, tgt_n;
  logic [2:0] fade, fade_n;
  logic [2:0] grant, grant_n;
  logic       pend_vld, pend_vld_n;
  pri_t       pend_pri, pend_pri_n;
  logic [3:0] pend_sel, pend_sel_n;
  logic       btn_d;

  logic       btn_rise, kb_ok, auto_req;
  logic       new_vld, take_new, start;
  pri_t       new_pri, start_pri;
  logic [3:0] commit, next_theme, start_sel;

  assign btn_rise   = bus.btn_req & ~btn_d;
  assign commit     = (state == IDLE) ? theme : tgt;
  assign kb_ok      = bus.kb_req
                    && ({1'b0, bus.kb_sel} < TN)
                    && (bus.kb_sel != commit);
  assign next_theme = (theme == TLAST) ? 4'd0 : theme + 4'd1;
  assign new_vld    = kb_ok | btn_rise | auto_req;
  assign new_pri    = kb_ok    ? P_KB
                    : btn_rise ? P_BTN
                    :            P_AUTO;
  // a newcomer wins over the slot unless the slot holds a stronger requester
  assign take_new   = new_vld && (!pend_vld || new_pri >= pend_pri);

`ifdef VGA_THEME_AUTO_EN
  localparam int CW = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
  localparam logic [CW-1:0] CLAST = CW'(AUTO_FRAMES - 1);

  logic [CW-1:0] cnt;

  assign auto_req = bus.frame_tick && (cnt == CLAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (btn_rise || kb_ok) begin
      cnt <= '0;
    end else if (bus.frame_tick) begin
      cnt <= (cnt == CLAST) ? '0 : cnt + 1'b1;
    end
  end
`else
  // no inactivity counter; AUTO_FRAMES has no effect in this build
  assign auto_req = (AUTO_FRAMES < 0);
`endif

  always_comb begin
    state_n    = state;
    theme_n    = theme;
    fade_n     = fade;
    tgt_n      = tgt;
    grant_n    = '0;
    pend_vld_n = pend_vld;
    pend_pri_n = pend_pri;
    pend_sel_n = pend_sel;
    start      = 1'b0;
    start_pri  = new_pri;
    start_sel  = bus.kb_sel;

    unique case (state)
      IDLE: begin
        pend_vld_n = 1'b0;
        if (take_new) begin
          start = 1'b1;
        end else if (pend_vld
                     && !(pend_pri == P_KB
                          && pend_sel == theme)) begin
          start     = 1'b1;
          start_pri = pend_pri;
          start_sel = pend_sel;
        end
        if (start) begin
          state_n = FADE_OUT;
          tgt_n   = (start_pri == P_KB) ? start_sel
                                        : next_theme;
          unique case (start_pri)
            P_KB:    grant_n = 3'b100;
            P_BTN:   grant_n = 3'b010;
            default: grant_n = 3'b001;
          endcase
        end
      end
      FADE_OUT: begin
        if (bus.frame_tick) begin
          fade_n = fade - 3'd1;
          if (fade == 3'd1) state_n = SWAP;
        end
      end
      SWAP: begin
        theme_n = tgt;
        state_n = FADE_IN;
      end
      FADE_IN: begin
        if (bus.frame_tick) begin
          fade_n = fade + 3'd1;
          if (fade == 3'd6) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    if (state != IDLE && take_new) begin
      pend_vld_n = 1'b1;
      pend_pri_n = new_pri;
      pend_sel_n = bus.kb_sel;
    end

`ifndef VGA_THEME_AUTO_EN
    grant_n[0] = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      theme    <= '0;
      fade     <= 3'd7;
      tgt      <= '0;
      grant    <= '0;
      pend_vld <= 1'b0;
      pend_pri <= P_AUTO;
      pend_sel <= '0;
      btn_d    <= 1'b0;
    end else begin
      state    <= state_n;
      theme    <= theme_n;
      fade     <= fade_n;
      tgt      <= tgt_n;
      grant    <= grant_n;
      pend_vld <= pend_vld_n;
      pend_pri <= pend_pri_n;
      pend_sel <= pend_sel_n;
      btn_d    <= bus.btn_req;
    end
  end

  assign bus.theme = theme;
  assign bus.fade  = fade;
  assign bus.busy  = (state != IDLE);
  assign bus.grant = grant;
endmodule

// File: tb/tb_vga_theme_sched.sv
// Bench for vga_theme_sched: directed scenarios plus random traffic
// checked every cycle against a sequence-level reference model.
module tb_vga_theme_sched;
`ifdef VGA_THEME_AUTO_EN
  localparam int AF = 4;
`else
  localparam int AF = 600;
`endif
  localparam int THEMES = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  vga_theme_if bus();

  vga_theme_sched #(
    .THEME_NUM  (THEMES),
    .AUTO_FRAMES(AF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // inputs as seen by the DUT at each rising edge
  logic       cap_ok;
  logic       c_tick, c_btn, c_kb;
  logic [3:0] c_sel;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_ok <= 1'b0;
    end else begin
      cap_ok <= 1'b1;
      c_tick <= bus.frame_tick;
      c_btn  <= bus.btn_req;
      c_kb   <= bus.kb_req;
      c_sel  <= bus.kb_sel;
    end
  end

  // reference model: a sequence is 14 ticks with one swap cycle after tick 7
  bit         m_busy, m_swapped, m_btn_d, pv;
  int         m_ticks, m_theme, m_tgt, pp, ps, m_cnt;
  logic [2:0] m_grant;

  task automatic model_reset();
    m_busy = 0; m_swapped = 0; m_btn_d = 0; pv = 0;
    m_ticks = 0; m_theme = 0; m_tgt = 0; pp = 0; ps = 0;
    m_cnt = 0; m_grant = '0;
  endtask

  task automatic model_step();
    bit rise, kok, aut, nv;
    int np, take, tsel, committed;
    rise = c_btn && !m_btn_d;
    m_btn_d = c_btn;
    committed = m_busy ? m_tgt : m_theme;
    kok = c_kb && (int'(c_sel) < THEMES) && (int'(c_sel) != committed);
    aut = 0;
`ifdef VGA_THEME_AUTO_EN
    aut = c_tick && (m_cnt == AF - 1);
    if (rise || kok) m_cnt = 0;
    else if (c_tick) m_cnt = (m_cnt + 1) % AF;
`endif
    nv = kok || rise || aut;
    np = kok ? 2 : (rise ? 1 : 0);
    m_grant = '0;
    if (!m_busy) begin
      take = -1;
      tsel = 0;
      if (nv && (!pv || np >= pp)) begin
        take = np; tsel = int'(c_sel);
      end else if (pv && !(pp == 2 && ps == m_theme)) begin
        take = pp; tsel = ps;
      end
      pv = 0;
      if (take >= 0) begin
        m_busy = 1; m_ticks = 0; m_swapped = 0;
        m_tgt = (take == 2) ? tsel : (m_theme + 1) % THEMES;
        m_grant = 3'(1 << take);
      end
    end else begin
      if (nv && (!pv || np >= pp)) begin
        pv = 1; pp = np; ps = int'(c_sel);
      end
      if (m_ticks == 7 && !m_swapped) begin
        m_theme = m_tgt;
        m_swapped = 1;
      end else if (c_tick) begin
        m_ticks++;
        if (m_ticks == 14) m_busy = 0;
      end
    end
  endtask

  initial begin
    int ef;
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst) model_reset();
      else if (cap_ok) model_step();
      ef = !m_busy ? 7 : (m_ticks <= 7 ? 7 - m_ticks : m_ticks - 7);
      n_cmp++;
      if (bus.theme !== 4'(m_theme) || bus.fade !== 3'(ef)
          || bus.busy !== m_busy || bus.grant !== m_grant) begin
        n_err++;
        $display("FAIL model t=%0t theme %0d/%0d fade %0d/%0d busy %0b/%0b grant %b/%b (got/exp)",
                 $time, bus.theme, m_theme, bus.fade, ef,
                 bus.busy, m_busy, bus.grant, m_grant);
      end
    end
  end

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick1();
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
  endtask

  task automatic press();
    bus.btn_req = 1'b1;
    @(negedge clk);
    bus.btn_req = 1'b0;
  endtask

  task automatic kb(input int sel);
    bus.kb_req = 1'b1;
    bus.kb_sel = 4'(sel);
    @(negedge clk);
    bus.kb_req = 1'b0;
  endtask

  task automatic finish_seq();
    repeat (7) tick1();
    @(negedge clk);
    repeat (7) tick1();
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    chk("rst_theme", int'(bus.theme), 0);
    chk("rst_fade", int'(bus.fade), 7);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_grant", int'(bus.grant), 0);
    @(negedge clk);
    #3 rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    bus.frame_tick = 1'b0;
    bus.btn_req    = 1'b0;
    bus.kb_req     = 1'b0;
    bus.kb_sel     = 4'd0;
    repeat (3) @(negedge clk);
    chk("init_fade", int'(bus.fade), 7);
    chk("init_busy", int'(bus.busy), 0);
    #3 rst = 1'b1;
    @(negedge clk);

`ifndef VGA_THEME_AUTO_EN
    // basic btn sequence
    press();
    chk("btn_grant", int'(bus.grant), 3'b010);
    chk("btn_busy", int'(bus.busy), 1);
    for (int i = 1; i <= 7; i++) begin
      tick1();
      chk("fo_fade", int'(bus.fade), 7 - i);
    end
    chk("pre_swap_theme", int'(bus.theme), 0);
    @(negedge clk);
    chk("swap_theme", int'(bus.theme), 1);
    for (int i = 1; i <= 7; i++) begin
      tick1();
      chk("fi_fade", int'(bus.fade), i);
      chk("fi_busy", int'(bus.busy), i < 7 ? 1 : 0);
    end
    // wrap and ignored kb requests
    press(); finish_seq();
    chk("theme2", int'(bus.theme), 2);
    press(); finish_seq();
    chk("wrap_theme", int'(bus.theme), 0);
    kb(5);
    chk("kb_bad_grant", int'(bus.grant), 0);
    chk("kb_bad_busy", int'(bus.busy), 0);
    kb(0);
    chk("kb_same_grant", int'(bus.grant), 0);
    // simultaneous btn + kb
    bus.btn_req = 1'b1;
    kb(2);
    bus.btn_req = 1'b0;
    chk("both_grant", int'(bus.grant), 3'b100);
    finish_seq();
    chk("both_theme", int'(bus.theme), 2);
    @(negedge clk);
    chk("btn_dropped", int'(bus.busy), 0);
    // pending kb overrides pending btn
    kb(1); finish_seq();
    chk("kb1_theme", int'(bus.theme), 1);
    press();
    chk("p_first_grant", int'(bus.grant), 3'b010);
    press();
    kb(0);
    finish_seq();
    chk("p_mid_theme", int'(bus.theme), 2);
    chk("p_mid_busy", int'(bus.busy), 0);
    @(negedge clk);
    chk("p_grant", int'(bus.grant), 3'b100);
    finish_seq();
    chk("p_theme", int'(bus.theme), 0);
`endif

    // reset in the middle of fade-in
    press();
    repeat (7) tick1();
    @(negedge clk);
    repeat (3) tick1();
    chk("mid_fade", int'(bus.fade), 3);
    do_reset();

`ifdef VGA_THEME_AUTO_EN
    repeat (4) tick1();
    chk("auto_grant", int'(bus.grant), 3'b001);
    finish_seq();
    chk("auto_theme", int'(bus.theme), 1);
`endif

    repeat (3000) begin
      bus.frame_tick = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) bus.btn_req = ~bus.btn_req;
      bus.kb_req = ($urandom_range(0, 9) == 0);
      bus.kb_sel = 4'($urandom_range(0, 5));
      @(negedge clk);
    end
    bus.frame_tick = 1'b0;
    bus.btn_req    = 1'b0;
    bus.kb_req     = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/vga_theme_sched.md
VGA_THEME_SCHED -- requirements
Module: vga_theme_sched

Interface
REQ-001 Parameter THEME_NUM, default 3, number of themes; legal theme codes are 0..THEME_NUM-1 (0 dark, 1 bright, 2 custom).
REQ-002 Parameter AUTO_FRAMES, default 600, frames of user inactivity before an auto-cycle request.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 frame_tick  input  1  one-cycle pulse per VGA frame (vsync start).
REQ-006 btn_req  input  1  debounced push-button level; its rising edge requests "next theme".
REQ-007 kb_req  input  1  one-cycle keyboard pulse requesting a jump to kb_sel.
REQ-008 kb_sel  input  4  target theme code for kb_req.
REQ-009 theme  output  4  active theme code.
REQ-010 fade  output  3  brightness scale for the pixel path; 7 full, 0 black.
REQ-011 busy  output  1  high whenever the state is not IDLE.
REQ-012 grant  output  3  one-hot, one-cycle pulse on sequence start: [2] kb, [1] btn, [0] auto.

Function
REQ-013 The FSM SHALL use states IDLE, FADE_OUT, SWAP, and FADE_IN.
REQ-014 Request priority SHALL be kb > btn > auto; when requests arrive simultaneously, only the highest is taken and the others are dropped.
REQ-015 A kb_req SHALL be ignored if kb_sel >= THEME_NUM or kb_sel equals the target currently committed (theme when idle, else the in-flight target).
REQ-016 Button rising edge SHALL be detected internally with a one-cycle delay register; a held button produces exactly one request.
REQ-017 In IDLE with a winning request (or a stored pending request): next cycle -> FADE_OUT, latch target, pulse grant, assert busy.
REQ-018 Target SHALL be kb_sel for kb; for btn and auto it is theme+1, wrapping THEME_NUM-1 -> 0.
REQ-019 In FADE_OUT, fade SHALL decrement by 1 on each frame_tick; on the tick that makes fade 0 -> SWAP.
REQ-020 SWAP SHALL last exactly one cycle: theme <= latched target, then -> FADE_IN.
REQ-021 In FADE_IN, fade SHALL increment by 1 on each frame_tick; on the tick that makes fade 7 -> IDLE.
REQ-022 Full sequence latency SHALL be 14 frame_ticks plus 1 cycle; theme never changes while fade != 0.
REQ-023 Requests arriving while busy SHALL go to a single pending slot; they overwrite the slot only if their priority is >= the stored priority; a pending kb request stores its own kb_sel.
REQ-024 On entry to IDLE with the slot valid, the FSM SHALL start the pending request on the next cycle, clear the slot, and pulse the grant bit of the stored requester; a pending request whose target equals the new theme is discarded.
REQ-025 frame_tick and a new request in the same cycle: the request is registered and the tick is not applied to the new sequence.
REQ-026 fade and theme SHALL be registered outputs with no combinational path from inputs.

Reset
REQ-027 On rst low, asynchronously: state IDLE, theme 0, fade 7, busy 0, grant 0, pending slot cleared, edge register 0, auto counter 0.
REQ-028 Reset mid-sequence SHALL abandon the sequence; no partial theme update survives.

Configuration
REQ-029 Macro VGA_THEME_AUTO_EN defined: a frame counter increments on frame_tick; it clears on any accepted btn or kb request and on reaching AUTO_FRAMES-1, where it raises an auto request that cycle.
REQ-030 Macro VGA_THEME_AUTO_EN undefined: no counter is built, there is no auto requester, and grant[0] is tied to 0; all other behaviour is unchanged.

Verification
REQ-031 Reset, then btn rising edge, 14 ticks -> grant=010; fade 7..0, theme 0->1 in SWAP, fade 0..7; busy drops after the 14th tick.
REQ-032 theme=2, btn edge -> theme wraps to 0; kb_req kb_sel=5 -> ignored, no grant; kb_sel=theme -> ignored.
REQ-033 Same cycle btn edge + kb_req kb_sel=2 from theme 0 -> grant=100, final theme 2, button request dropped.
REQ-034 During FADE_OUT: btn edge then kb_req sel=0 -> pending kb; after first sequence, second starts next cycle with grant=100 and ends at theme 0.
REQ-035 rst low during FADE_IN at fade=3 -> theme 0, fade 7, busy 0 immediately; with VGA_THEME_AUTO_EN and AUTO_FRAMES=4, 4 idle ticks -> grant=001, theme 1.
